// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier (radix-2 or radix-4 per operation).
// Controller and datapath share one register set; product is held until the next completion.
module booth_mult_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic                 abort_i,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int AW = WIDTH + 2;
    localparam int SW = AW + WIDTH + 1;
    localparam logic [CNT_W-1:0] N_R2  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] N_R4  = CNT_W'(WIDTH / 2);
    localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     m_r;
    logic [AW-1:0]        a_r;
    logic [WIDTH-1:0]     q_r;
    logic                 qm1_r;
    logic                 mode_r;
    logic [CNT_W-1:0]     count_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;

    logic [AW-1:0]        m_ext_s;
    logic [AW-1:0]        addend_s;
    logic [AW-1:0]        sum_s;
    logic [SW-1:0]        shift_in_s;
    logic [SW-1:0]        shifted_s;
    logic [AW-1:0]        a_next_s;
    logic [WIDTH-1:0]     q_next_s;
    logic                 qm1_next_s;

    // Booth recoding: bits = {Q[1], Q[0], Q-1}; radix-2 only looks at the low pair.
    function automatic logic [AW-1:0] booth_addend(
        input logic          mode,
        input logic [2:0]    bits,
        input logic [AW-1:0] m_ext
    );
        logic [AW-1:0] m2;
        m2 = m_ext << 1;
        booth_addend = {AW{1'b0}};
        if (!mode) begin
            case (bits[1:0])
                2'b01:   booth_addend = m_ext;
                2'b10:   booth_addend = -m_ext;
                default: booth_addend = {AW{1'b0}};
            endcase
        end else begin
            case (bits)
                3'b001, 3'b010: booth_addend = m_ext;
                3'b011:         booth_addend = m2;
                3'b100:         booth_addend = -m2;
                3'b101, 3'b110: booth_addend = -m_ext;
                default:        booth_addend = {AW{1'b0}};
            endcase
        end
    endfunction

    assign m_ext_s    = {{2{m_r[WIDTH-1]}}, m_r};
    assign addend_s   = booth_addend(mode_r, {q_r[1:0], qm1_r}, m_ext_s);
    assign sum_s      = a_r + addend_s;
    assign shift_in_s = {sum_s, q_r, qm1_r};

    // Arithmetic right shift of {A,Q,Q-1} by one or two places, replicating A's MSB.
    always_comb begin
        shifted_s = {SW{1'b0}};
        if (mode_r) begin
            shifted_s = {{2{sum_s[AW-1]}}, shift_in_s[SW-1:2]};
        end else begin
            shifted_s = {sum_s[AW-1], shift_in_s[SW-1:1]};
        end
    end

    assign a_next_s   = shifted_s[SW-1 -: AW];
    assign q_next_s   = shifted_s[WIDTH:1];
    assign qm1_next_s = shifted_s[0];

    // Controller and datapath registers, outputs registered alongside the state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r   <= ST_IDLE;
            m_r       <= {WIDTH{1'b0}};
            a_r       <= {AW{1'b0}};
            q_r       <= {WIDTH{1'b0}};
            qm1_r     <= 1'b0;
            mode_r    <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        m_r     <= multiplicand_i;
                        a_r     <= {AW{1'b0}};
                        q_r     <= multiplier_i;
                        qm1_r   <= 1'b0;
                        mode_r  <= mode_i;
                        count_r <= mode_i ? N_R4 : N_R2;
                        state_r <= ST_CALC;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (abort_i) begin
                        // Cancel leaves product_r untouched and raises no done.
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        a_r     <= a_next_s;
                        q_r     <= q_next_s;
                        qm1_r   <= qm1_next_s;
                        count_r <= count_r - CNT_1;
                        if (count_r == CNT_1) begin
                            product_r <= {a_next_s[WIDTH-1:0], q_next_s};
                            state_r   <= ST_DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            state_r <= ST_CALC;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o   = ready_r;
    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign product_o = product_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=8 and WIDTH=16, both radix modes.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s8 = 1'b0, md8 = 1'b0, ab8 = 1'b0;
    logic [7:0]  m8 = 8'h00, q8 = 8'h00;
    logic        rdy8, bsy8, dn8;
    logic [15:0] p8;

    logic        s16 = 1'b0, md16 = 1'b0, ab16 = 1'b0;
    logic [15:0] m16 = 16'h0000, q16 = 16'h0000;
    logic        rdy16, bsy16, dn16;
    logic [31:0] p16;

    int checks = 0;
    int passes = 0;

    logic [7:0]  tm8 [6] = '{8'h80, 8'h00, 8'hFF, 8'h7F, 8'hFB, 8'h64};
    logic [7:0]  tq8 [6] = '{8'h80, 8'hFF, 8'hFF, 8'h7F, 8'h06, 8'h9C};
    logic [15:0] te8 [6] = '{16'h4000, 16'h0000, 16'h0001, 16'h3F01, 16'hFFE2, 16'hD8F0};

    logic [15:0] tm16 [5] = '{16'h8000, 16'h04D2, 16'h7FFF, 16'hFED4, 16'h8000};
    logic [15:0] tq16 [5] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h00C8, 16'h7FFF};
    logic [31:0] te16 [5] = '{32'h40000000, 32'hFFFFFB2E, 32'h3FFF0001, 32'hFFFF15A0, 32'hC0008000};

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(s8), .mode_i(md8), .abort_i(ab8),
        .multiplicand_i(m8), .multiplier_i(q8),
        .ready_o(rdy8), .busy_o(bsy8), .done_o(dn8), .product_o(p8)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(s16), .mode_i(md16), .abort_i(ab16),
        .multiplicand_i(m16), .multiplier_i(q16),
        .ready_o(rdy16), .busy_o(bsy16), .done_o(dn16), .product_o(p16)
    );

    // Called at a falling edge with ready high; returns product, latency and busy cycles.
    task automatic run8(input logic [7:0] m, input logic [7:0] q, input logic md, input int poke,
                        output logic [15:0] prod, output int lat, output int bcnt);
        m8 = m; q8 = q; md8 = md; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0; lat = 0; bcnt = 0;
        while (dn8 !== 1'b1 && lat < 40) begin
            if (bsy8 === 1'b1) bcnt++;
            s8 = (lat == poke);
            if (lat == poke) m8 = 8'h01;
            @(negedge clk);
            lat++;
        end
        s8 = 1'b0;
        prod = p8;
    endtask

    task automatic run16(input logic [15:0] m, input logic [15:0] q, input logic md,
                         output logic [31:0] prod, output int lat);
        m16 = m; q16 = q; md16 = md; s16 = 1'b1;
        @(negedge clk);
        s16 = 1'b0; lat = 0;
        while (dn16 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        prod = p16;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({rdy8, bsy8, dn8, p8} !== {3'b100, 16'h0000}) $display("FAIL reset8_held: got %b %h expected 100 0000", {rdy8, bsy8, dn8}, p8);
        else passes++;
        checks++;
        if ({rdy16, bsy16, dn16, p16} !== {3'b100, 32'h0}) $display("FAIL reset16_held: got %b %h expected 100 0", {rdy16, bsy16, dn16}, p16);
        else passes++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({rdy8, bsy8, dn8, p8} !== {3'b100, 16'h0000}) $display("FAIL reset8_released: got %b %h expected 100 0000", {rdy8, bsy8, dn8}, p8);
        else passes++;
    endtask

    task automatic test_radix2();
        logic [15:0] pr; int lat, bc;
        run8(8'h07, 8'hFD, 1'b0, -1, pr, lat, bc);
        checks++;
        if (pr !== 16'hFFEB) $display("FAIL r2_product: got %h expected FFEB", pr); else passes++;
        checks++;
        if (lat !== 8) $display("FAIL r2_latency: got %0d expected 8", lat); else passes++;
        checks++;
        if (bc !== 8) $display("FAIL r2_busy_cycles: got %0d expected 8", bc); else passes++;
        @(negedge clk);
        checks++;
        if ({dn8, rdy8} !== 2'b01) $display("FAIL r2_done_pulse: got done=%b ready=%b expected 0 1", dn8, rdy8); else passes++;
    endtask

    task automatic test_radix4();
        logic [15:0] pr; int lat, bc;
        run8(8'h80, 8'h7F, 1'b1, -1, pr, lat, bc);
        checks++;
        if (pr !== 16'hC080) $display("FAIL r4_product: got %h expected C080", pr); else passes++;
        checks++;
        if (lat !== 4) $display("FAIL r4_latency: got %0d expected 4", lat); else passes++;
        checks++;
        if (bc !== 4) $display("FAIL r4_busy_cycles: got %0d expected 4", bc); else passes++;
        @(negedge clk);
        checks++;
        if ({dn8, rdy8} !== 2'b01) $display("FAIL r4_done_pulse: got done=%b ready=%b expected 0 1", dn8, rdy8); else passes++;
    endtask

    task automatic test_corners8();
        logic [15:0] pr; int lat, bc;
        for (int md = 0; md < 2; md++) begin
            for (int i = 0; i < 6; i++) begin
                run8(tm8[i], tq8[i], md[0], -1, pr, lat, bc);
                checks++;
                if (pr !== te8[i] || lat !== (md == 1 ? 4 : 8))
                    $display("FAIL corner8 mode=%0d %h*%h: got %h lat %0d expected %h", md, tm8[i], tq8[i], pr, lat, te8[i]);
                else passes++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_width16();
        logic [31:0] pr; int lat;
        for (int md = 0; md < 2; md++) begin
            for (int i = 0; i < 5; i++) begin
                run16(tm16[i], tq16[i], md[0], pr, lat);
                checks++;
                if (pr !== te16[i] || lat !== (md == 1 ? 8 : 16))
                    $display("FAIL w16 mode=%0d %h*%h: got %h lat %0d expected %h", md, tm16[i], tq16[i], pr, lat, te16[i]);
                else passes++;
                @(negedge clk);
            end
        end
    endtask

    // start held high: each op must be accepted the cycle ready returns, N+2 apart.
    task automatic test_back_to_back8(input logic md);
        int n, cyc;
        n = md ? 4 : 8;
        md8 = md; s8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m8 = tm8[i]; q8 = tq8[i];
            @(negedge clk);
            m8 = ~tm8[i]; q8 = 8'h5A; md8 = ~md;
            cyc = 0;
            while (dn8 !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            md8 = md;
            checks++;
            if (cyc !== n || p8 !== te8[i])
                $display("FAIL b2b8 mode=%0d op%0d: got %h at %0d expected %h at %0d", md, i, p8, cyc, te8[i], n);
            else passes++;
            @(negedge clk);
            if (i == 5) s8 = 1'b0;
            checks++;
            if ({dn8, rdy8} !== 2'b01) $display("FAIL b2b8_ready mode=%0d op%0d: got done=%b ready=%b expected 0 1", md, i, dn8, rdy8);
            else passes++;
        end
    endtask

    task automatic test_back_to_back16(input logic md);
        int n, cyc;
        n = md ? 8 : 16;
        md16 = md; s16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            m16 = tm16[i]; q16 = tq16[i];
            @(negedge clk);
            m16 = 16'h1234; q16 = 16'hA5A5;
            cyc = 0;
            while (dn16 !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc !== n || p16 !== te16[i])
                $display("FAIL b2b16 mode=%0d op%0d: got %h at %0d expected %h at %0d", md, i, p16, cyc, te16[i], n);
            else passes++;
            @(negedge clk);
            if (i == 4) s16 = 1'b0;
            checks++;
            if (rdy16 !== 1'b1) $display("FAIL b2b16_ready mode=%0d op%0d: got %b expected 1", md, i, rdy16);
            else passes++;
        end
    endtask

    task automatic test_start_mid();
        logic [15:0] pr; int lat, bc;
        run8(8'h64, 8'h9C, 1'b0, 3, pr, lat, bc);
        checks++;
        if (pr !== 16'hD8F0 || lat !== 8) $display("FAIL start_mid: got %h lat %0d expected D8F0 lat 8", pr, lat);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [15:0] prev; int seen;
        prev = p8;
        m8 = 8'h07; q8 = 8'hFD; md8 = 1'b0; s8 = 1'b1;
        @(negedge clk); s8 = 1'b0;
        @(negedge clk); @(negedge clk);
        ab8 = 1'b1;
        @(negedge clk);
        ab8 = 1'b0;
        checks++;
        if ({rdy8, bsy8, dn8} !== 3'b100) $display("FAIL abort_state: got %b expected 100", {rdy8, bsy8, dn8}); else passes++;
        checks++;
        if (p8 !== prev) $display("FAIL abort_product: got %h expected %h", p8, prev); else passes++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dn8 === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", seen); else passes++;
    endtask

    task automatic test_reset_mid();
        m8 = 8'h07; q8 = 8'hFD; md8 = 1'b0; s8 = 1'b1;
        m16 = 16'h7FFF; q16 = 16'h7FFF; md16 = 1'b1; s16 = 1'b1;
        @(negedge clk); s8 = 1'b0; s16 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy8, bsy8, dn8, p8} !== {3'b100, 16'h0000}) $display("FAIL reset_mid8: got %b %h expected 100 0000", {rdy8, bsy8, dn8}, p8);
        else passes++;
        checks++;
        if ({rdy16, bsy16, dn16, p16} !== {3'b100, 32'h0}) $display("FAIL reset_mid16: got %b %h expected 100 0", {rdy16, bsy16, dn16}, p16);
        else passes++;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        checks++;
        if ({rdy8, dn8, p8} !== {2'b10, 16'h0000}) $display("FAIL reset_mid_after: got %b %h expected 10 0000", {rdy8, dn8}, p8);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_radix2();
        test_radix4();
        test_corners8();
        test_width16();
        test_back_to_back8(1'b0);
        test_back_to_back8(1'b1);
        test_back_to_back16(1'b0);
        test_back_to_back16(1'b1);
        test_start_mid();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
